// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the CPU MEM-stage data port. Accepts one load or
// store at a time over a req/ready handshake, waits WAIT_STATES cycles, then
// performs a 16-bit word or 8-bit byte access on an internal word RAM and
// pulses resp_valid for one cycle. After reset the whole RAM is zeroed, one
// word per cycle, before the first request is accepted.
//
// Parameters
//   DEPTH_WORDS  number of 16-bit words (byte address space = 2*DEPTH_WORDS)
//   WAIT_STATES  extra cycles between acceptance and access (0..15)
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-low
//   req         in   request valid
//   we          in   1 = store, 0 = load
//   byte_en     in   1 = byte access, 0 = word access
//   addr[15:0]  in   byte address
//   wdata[15:0] in   store data (byte store uses wdata[7:0])
//   ready       out  high only in IDLE; request taken on req && ready
//   resp_valid  out  one-cycle completion pulse
//   rdata[15:0] out  load data (byte load zero-extended), 0 otherwise
//   addr_err    out  misaligned word access or address beyond the RAM
//   stall       out  high whenever the responder is not IDLE
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic        byte_en,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic        resp_valid,
   output logic [15:0] rdata,
   output logic        addr_err,
   output logic        stall
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] clr_idx;
   logic [3:0]    cnt;

   // Request captured at acceptance
   logic          lat_we;
   logic          lat_byte_en;
   logic [15:0]   lat_addr;
   logic [15:0]   lat_wdata;

   logic [15:0]   mem [DEPTH_WORDS];

   // Access operands and decode
   logic          do_access;
   logic          acc_we;
   logic          acc_byte;
   logic [15:0]   acc_addr;
   logic [15:0]   acc_wdata;
   logic          acc_err;
   logic [AW-1:0] acc_idx;
   logic [15:0]   rd_word;
   logic [15:0]   rd_val;
   logic          wr_ok;
   logic          wr_lo;
   logic          wr_hi;
   logic [7:0]    wr_hi_data;

   // Next-state and decoded outputs
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      stall     = 1'b1;
      case (state)
         CLEAR: begin
            if (clr_idx == AW'(DEPTH_WORDS - 1)) state_nxt = IDLE;
         end
         IDLE: begin
            ready = 1'b1;
            stall = 1'b0;
            if (req) state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
         end
         WAIT: begin
            if (cnt == 4'd1) state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = CLEAR;
         end
      endcase
   end

   // The access happens on the edge that enters RESP. With zero wait states
   // that is the accept edge itself, so the live inputs are used instead of
   // the (not yet loaded) latched copy.
   always_comb begin
      do_access = (state_nxt == RESP);
      if (state == IDLE) begin
         acc_we    = we;
         acc_byte  = byte_en;
         acc_addr  = addr;
         acc_wdata = wdata;
      end else begin
         acc_we    = lat_we;
         acc_byte  = lat_byte_en;
         acc_addr  = lat_addr;
         acc_wdata = lat_wdata;
      end
      acc_err    = (!acc_byte && acc_addr[0]) ||
                   (32'(acc_addr[15:1]) >= DEPTH_WORDS);
      acc_idx    = acc_addr[AW:1];
      rd_word    = mem[acc_idx];
      rd_val     = acc_byte ? {8'h00, (acc_addr[0] ? rd_word[15:8] : rd_word[7:0])}
                            : rd_word;
      // No write may land on an edge where reset is asserted
      wr_ok      = reset && do_access && acc_we && !acc_err;
      wr_lo      = wr_ok && (!acc_byte || !acc_addr[0]);
      wr_hi      = wr_ok && (!acc_byte ||  acc_addr[0]);
      wr_hi_data = acc_byte ? acc_wdata[7:0] : acc_wdata[15:8];
   end

   // Control state and registered response
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= CLEAR;
         clr_idx    <= '0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         rdata      <= '0;
         addr_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
         if (state == IDLE && req) begin
            cnt <= 4'(WAIT_STATES);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         resp_valid <= do_access;
         addr_err   <= do_access && acc_err;
         rdata      <= (do_access && !acc_we && !acc_err) ? rd_val : 16'h0000;
      end
   end

   // Request capture
   always_ff @(posedge clock) begin
      if (state == IDLE && req) begin
         lat_we      <= we;
         lat_byte_en <= byte_en;
         lat_addr    <= addr;
         lat_wdata   <= wdata;
      end
   end

   // RAM: sequential zero-fill during CLEAR, lane-masked stores otherwise
   always_ff @(posedge clock) begin
      if (reset && state == CLEAR) begin
         mem[clr_idx] <= 16'h0000;
      end else begin
         if (wr_lo) mem[acc_idx][7:0]  <= acc_wdata[7:0];
         if (wr_hi) mem[acc_idx][15:8] <= wr_hi_data;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (256 words / 2 wait states and
// 8 words / 0 wait states) driven with random requests. A byte-addressed
// reference memory predicts each response and its cycle; a monitor compares.
module tb_data_mem_responder;

   localparam int DEP0 = 256;
   localparam int WS0  = 2;
   localparam int DEP1 = 8;
   localparam int WS1  = 0;

   logic        clock = 1'b0;
   logic        reset;
   logic        req       [2];
   logic        we        [2];
   logic        byte_en   [2];
   logic [15:0] addr      [2];
   logic [15:0] wdata     [2];
   logic        ready     [2];
   logic        resp_valid[2];
   logic [15:0] rdata     [2];
   logic        addr_err  [2];
   logic        stall     [2];

   always #5 clock = ~clock;

   data_mem_responder #(.DEPTH_WORDS(DEP0), .WAIT_STATES(WS0)) u_dut_ws2 (
      .clock(clock), .reset(reset), .req(req[0]), .we(we[0]), .byte_en(byte_en[0]),
      .addr(addr[0]), .wdata(wdata[0]), .ready(ready[0]), .resp_valid(resp_valid[0]),
      .rdata(rdata[0]), .addr_err(addr_err[0]), .stall(stall[0]));

   data_mem_responder #(.DEPTH_WORDS(DEP1), .WAIT_STATES(WS1)) u_dut_ws0 (
      .clock(clock), .reset(reset), .req(req[1]), .we(we[1]), .byte_en(byte_en[1]),
      .addr(addr[1]), .wdata(wdata[1]), .ready(ready[1]), .resp_valid(resp_valid[1]),
      .rdata(rdata[1]), .addr_err(addr_err[1]), .stall(stall[1]));

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t        sb [2][$];
   logic [7:0]  mdl [2][512];
   int          idle_at [2];
   int          hold [2];
   int          cyc = 0;
   bit          armed = 1'b0;
   bit          run_drv = 1'b0;
   int          n_vec = 0;
   int          n_bad = 0;

   int          c_m;
   int          ia_m;
   logic [15:0] a_m;
   exp_t        e_m;
   exp_t        e_mon;

   function automatic int dep(input int i);
      return (i == 0) ? DEP0 : DEP1;
   endfunction

   function automatic int ws(input int i);
      return (i == 0) ? WS0 : WS1;
   endfunction

   task automatic check(input string name, input int i, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
      end
   endtask

   // Reference model, evaluated at every rising edge for the cycle that ends.
   // A response for a request accepted in cycle c appears in cycle c+ws+1 and
   // the responder is ready again in cycle c+ws+2. Reset restarts the zero
   // fill, which leaves the responder busy for DEPTH cycles after the edge.
   initial begin
      idle_at[0] = 32'h3fff_ffff;
      idle_at[1] = 32'h3fff_ffff;
   end

   always @(posedge clock) begin
      c_m = cyc;
      if (reset === 1'b0) begin
         armed = 1'b1;
         for (int i = 0; i < 2; i++) begin
            sb[i].delete();
            for (int b = 0; b < 512; b++) mdl[i][b] = 8'h00;
            idle_at[i] = c_m + dep(i) + 1;
         end
      end else if (armed) begin
         for (int i = 0; i < 2; i++) begin
            if (req[i] === 1'b1 && c_m >= idle_at[i]) begin
               a_m      = addr[i];
               ia_m     = int'(a_m);
               e_m.due  = c_m + ws(i) + 1;
               e_m.err  = (!byte_en[i] && a_m[0]) || (ia_m >= 2 * dep(i));
               e_m.rdata = 16'h0000;
               if (!e_m.err) begin
                  if (we[i]) begin
                     mdl[i][ia_m] = wdata[i][7:0];
                     if (!byte_en[i]) mdl[i][ia_m + 1] = wdata[i][15:8];
                  end else if (byte_en[i]) begin
                     e_m.rdata = {8'h00, mdl[i][ia_m]};
                  end else begin
                     e_m.rdata = {mdl[i][ia_m + 1], mdl[i][ia_m]};
                  end
               end
               sb[i].push_back(e_m);
               idle_at[i] = c_m + ws(i) + 2;
            end
         end
      end
      cyc = cyc + 1;
   end

   // Monitor: compares handshake outputs every cycle and responses as they appear
   always @(negedge clock) begin
      if (armed) begin
         for (int i = 0; i < 2; i++) begin
            check("ready", i, 32'(ready[i]), 32'(cyc >= idle_at[i]));
            check("stall", i, 32'(stall[i]), 32'(cyc < idle_at[i]));
            if (resp_valid[i] === 1'b1) begin
               if (sb[i].size() == 0) begin
                  check("unexpected_resp", i, 32'd1, 32'd0);
               end else begin
                  e_mon = sb[i].pop_front();
                  check("resp_cycle", i, 32'(cyc), 32'(e_mon.due));
                  check("rdata", i, 32'(rdata[i]), 32'(e_mon.rdata));
                  check("addr_err", i, 32'(addr_err[i]), 32'(e_mon.err));
               end
            end else begin
               check("quiet_outputs", i, {15'd0, addr_err[i], rdata[i]}, 32'd0);
               if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
                  check("missing_resp", i, 32'(resp_valid[i]), 32'd1);
                  void'(sb[i].pop_front());
               end
            end
         end
      end
   end

   task automatic new_op(input int i);
      int lim;
      int r;
      lim = 2 * dep(i);
      r   = $urandom_range(0, 9);
      if (r < 6)      addr[i] = 16'($urandom_range(0, (i == 0) ? 63 : lim - 1));
      else if (r < 8) addr[i] = 16'(lim - 4 + $urandom_range(0, 7));
      else            addr[i] = 16'($urandom());
      we[i]      = 1'($urandom_range(0, 1));
      byte_en[i] = 1'($urandom_range(0, 1));
      wdata[i]   = 16'($urandom());
   endtask

   // Driver: random requests regardless of ready, plus stretches of req held
   // high with a fixed operation to exercise back-to-back acceptance.
   initial begin
      forever begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) begin
            if (!run_drv) begin
               req[i] = 1'b0;
            end else if (hold[i] > 0) begin
               req[i] = 1'b1;
               hold[i]--;
            end else begin
               new_op(i);
               if ($urandom_range(0, 19) == 0) begin
                  hold[i] = 12;
                  req[i]  = 1'b1;
               end else begin
                  req[i] = 1'($urandom_range(0, 1));
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i]     = 1'b0;
         we[i]      = 1'b0;
         byte_en[i] = 1'b0;
         addr[i]    = 16'h0000;
         wdata[i]   = 16'h0000;
         hold[i]    = 0;
      end
      repeat (3) @(negedge clock);
      reset   = 1'b1;
      run_drv = 1'b1;
      repeat (1500 + $urandom_range(0, 50)) @(negedge clock);
      // Reset while a request is in flight on the waiting instance
      for (int k = 0; k < 50 && sb[0].size() == 0; k++) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      repeat (1500) @(negedge clock);
      run_drv = 1'b0;
      repeat (10) @(negedge clock);
      for (int i = 0; i < 2; i++) check("drain", i, 32'(sb[i].size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
